// File: rtl/addsub_pkg.sv
// Shared types and helpers for the chunked adder-subtractor.
// Saturation helper is only referenced when ADDSUB_SAT_EN is defined.
package addsub_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Signed saturation limit for the given operand sign, width <= 64.
  function automatic logic [63:0] sat_value(input logic sign_bit, input int unsigned width);
    logic [63:0] min_neg;
    min_neg = 64'd1 << (width - 32'd1);
    return sign_bit ? min_neg : (min_neg - 64'd1);
  endfunction

endpackage

// File: rtl/addsub_chunk.sv
// Combinational CHUNK-bit ripple-carry adder slice; also exposes the
// carry into its MSB so the caller can form signed overflow.
module addsub_chunk #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             c_i,
  output logic [CHUNK-1:0] sum_c_o,
  output logic             cout_c_o,
  output logic             cmsb_c_o
);

  logic [CHUNK:0] carry;

  always_comb begin
    carry    = '0;
    sum_c_o  = '0;
    carry[0] = c_i;
    for (int unsigned i = 0; i < CHUNK; i++) begin
      sum_c_o[i]  = a_i[i] ^ b_i[i] ^ carry[i];
      carry[i+1]  = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
    end
  end

  assign cout_c_o = carry[CHUNK];
  assign cmsb_c_o = carry[CHUNK-1];

endmodule

// File: rtl/addsub_seq.sv
// Multi-cycle add/sub: WIDTH-bit operands pushed CHUNK bits per cycle through
// one shared ripple slice. Define ADDSUB_SAT_EN for signed saturation of oS.
module addsub_seq
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iValid,
  output logic             oReady,
  input  logic             iSub,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  output logic             oValid,
  input  logic             iReady,
  output logic [WIDTH-1:0] oS,
  output logic             oC,
  output logic             oV
);

  localparam int unsigned N     = WIDTH / CHUNK;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned PAD   = WIDTH - CHUNK;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, res_q, res_d, s_q, s_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sub_q, sub_d, carry_q, carry_d;
  logic               c_q, c_d, v_q, v_d;
  logic               ready_q, ready_d, valid_q, valid_d;

  logic [CHUNK-1:0]   sum_c;
  logic               cout_c, cmsb_c;

  // Operands are shifted right each cycle so the active chunk is always at bit 0.
  addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a_i      (a_q[CHUNK-1:0]),
    .b_i      (b_q[CHUNK-1:0]),
    .c_i      (carry_q),
    .sum_c_o  (sum_c),
    .cout_c_o (cout_c),
    .cmsb_c_o (cmsb_c)
  );

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      s_q     <= '0;
      cnt_q   <= '0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      sub_q   <= sub_d;
      carry_q <= carry_d;
      c_q     <= c_d;
      v_q     <= v_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    sub_d   = sub_q;
    carry_d = carry_q;
    c_d     = c_q;
    v_d     = v_q;

    case (state_q)
      ST_IDLE: begin
        if (iValid) begin
          a_d     = iA;
          b_d     = (iSub == MODE_ADD) ? iB : ~iB;
          sub_d   = iSub;
          carry_d = (iSub == MODE_SUB);
          cnt_d   = '0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // Result fills from the top: after N shifts the first chunk sits at bit 0.
        res_d   = (res_q >> CHUNK) | (WIDTH'(sum_c) << PAD);
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        carry_d = cout_c;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(N - 1)) begin
          state_d = ST_DONE;
          c_d     = cout_c ^ sub_q;
          v_d     = cout_c ^ cmsb_c;
`ifdef ADDSUB_SAT_EN
          s_d     = (cout_c ^ cmsb_c) ? WIDTH'(sat_value(a_q[CHUNK-1], WIDTH)) : res_d;
`else
          s_d     = res_d;
`endif
        end
      end
      ST_DONE: begin
        if (iReady) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    ready_d = (state_d == ST_IDLE);
    valid_d = (state_d == ST_DONE);
  end

  assign oReady = ready_q;
  assign oValid = valid_q;
  assign oS     = s_q;
  assign oC     = c_q;
  assign oV     = v_q;

endmodule

// File: tb/tb_addsub_seq.sv
// Directed-vector bench for addsub_seq: 16/4 chunked instance plus an 8/8
// single-cycle instance; expectations follow ADDSUB_SAT_EN when defined.
module tb_addsub_seq;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic [15:0] s_wrap;
    logic [15:0] s_sat;
    logic        c;
    logic        v;
  } vec_t;

  logic        iClk = 1'b0;
  logic        iRst = 1'b1;
  logic        iValid = 1'b0, iReady = 1'b0, iSub = 1'b0;
  logic [15:0] iA = '0, iB = '0;
  logic        oReady, oValid, oC, oV;
  logic [15:0] oS;

  logic        v8_in = 1'b0, r8_in = 1'b0, sub8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        rdy8, val8, c8, ov8;
  logic [7:0]  s8;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 iClk = ~iClk;

  addsub_seq #(.WIDTH(16), .CHUNK(4)) dut (
    .iClk(iClk), .iRst(iRst), .iValid(iValid), .oReady(oReady), .iSub(iSub),
    .iA(iA), .iB(iB), .oValid(oValid), .iReady(iReady), .oS(oS), .oC(oC), .oV(oV)
  );

  addsub_seq #(.WIDTH(8), .CHUNK(8)) dut8 (
    .iClk(iClk), .iRst(iRst), .iValid(v8_in), .oReady(rdy8), .iSub(sub8),
    .iA(a8), .iB(b8), .oValid(val8), .iReady(r8_in), .oS(s8), .oC(c8), .oV(ov8)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Present one operation, wait (bounded) for oValid; leaves DUT in DONE.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic sub,
                        output int lat);
    @(negedge iClk);
    iValid = 1'b1; iA = a; iB = b; iSub = sub;
    @(posedge iClk); #1;
    iValid = 1'b0; iA = 16'h0; iB = 16'h0; iSub = 1'b0;
    lat = 0;
    while (!oValid && lat < 20) begin
      @(posedge iClk); #1;
      lat++;
    end
  endtask

  task automatic ack;
    @(negedge iClk);
    iReady = 1'b1;
    @(posedge iClk); #1;
    iReady = 1'b0;
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic sub,
                      input logic [7:0] es, input logic ec, input logic ev);
    int lat;
    @(negedge iClk);
    v8_in = 1'b1; a8 = a; b8 = b; sub8 = sub;
    @(posedge iClk); #1;
    v8_in = 1'b0; a8 = 8'h0; b8 = 8'h0; sub8 = 1'b0;
    lat = 0;
    while (!val8 && lat < 20) begin
      @(posedge iClk); #1;
      lat++;
    end
    check("w8_latency", 32'(lat), 32'd1);
    check("w8_s", 32'(s8), 32'(es));
    check("w8_c", 32'(c8), 32'(ec));
    check("w8_v", 32'(ov8), 32'(ev));
    @(negedge iClk);
    r8_in = 1'b1;
    @(posedge iClk); #1;
    r8_in = 1'b0;
    check("w8_ready_after_ack", 32'(rdy8), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t vecs[10];
    int   lat;
    logic [15:0] exp_s;

    vecs[0] = '{16'h1234, 16'h0FFF, 1'b0, 16'h2233, 16'h2233, 1'b0, 1'b0};
    vecs[1] = '{16'h0003, 16'h0005, 1'b1, 16'hFFFE, 16'hFFFE, 1'b1, 1'b0};
    vecs[2] = '{16'h0005, 16'h0003, 1'b1, 16'h0002, 16'h0002, 1'b0, 1'b0};
    vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 16'h7FFF, 1'b0, 1'b1};
    vecs[4] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 16'h8000, 1'b0, 1'b1};
    vecs[5] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0};
    vecs[6] = '{16'h0000, 16'h0000, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0};
    vecs[7] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 16'h8000, 1'b1, 1'b1};
    vecs[8] = '{16'h7FFF, 16'hFFFF, 1'b1, 16'h8000, 16'h7FFF, 1'b1, 1'b1};
    vecs[9] = '{16'h1234, 16'h1234, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0};

    // Reset state
    repeat (3) @(posedge iClk);
    @(negedge iClk);
    iRst = 1'b0;
    check("rst_ready", 32'(oReady), 32'd1);
    check("rst_valid", 32'(oValid), 32'd0);
    check("rst_s", 32'(oS), 32'd0);
    check("rst_c", 32'(oC), 32'd0);
    check("rst_v", 32'(oV), 32'd0);

    // Table-driven vectors
    for (int i = 0; i < 10; i++) begin
`ifdef ADDSUB_SAT_EN
      exp_s = vecs[i].s_sat;
`else
      exp_s = vecs[i].s_wrap;
`endif
      run_op(vecs[i].a, vecs[i].b, vecs[i].sub, lat);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd4);
      check($sformatf("vec%0d_s", i), 32'(oS), 32'(exp_s));
      check($sformatf("vec%0d_c", i), 32'(oC), 32'(vecs[i].c));
      check($sformatf("vec%0d_v", i), 32'(oV), 32'(vecs[i].v));
      check($sformatf("vec%0d_ready_done", i), 32'(oReady), 32'd0);
      ack();
      check($sformatf("vec%0d_ready_idle", i), 32'(oReady), 32'd1);
      check($sformatf("vec%0d_valid_idle", i), 32'(oValid), 32'd0);
    end

    // Backpressure: held in DONE, new requests ignored
    run_op(16'h1234, 16'h0FFF, 1'b0, lat);
    check("bp_latency", 32'(lat), 32'd4);
    for (int k = 0; k < 10; k++) begin
      @(negedge iClk);
      iValid = 1'b1; iA = 16'hAAAA; iB = 16'h5555; iSub = 1'b1;
      @(posedge iClk); #1;
      check("bp_valid", 32'(oValid), 32'd1);
      check("bp_s", 32'(oS), 32'h2233);
      check("bp_c", 32'(oC), 32'd0);
      check("bp_v", 32'(oV), 32'd0);
      check("bp_ready", 32'(oReady), 32'd0);
    end
    @(negedge iClk);
    iValid = 1'b0; iReady = 1'b1;
    @(posedge iClk); #1;
    iReady = 1'b0;
    check("bp_release_ready", 32'(oReady), 32'd1);
    check("bp_release_valid", 32'(oValid), 32'd0);
    check("bp_idle_hold_s", 32'(oS), 32'h2233);
    repeat (6) @(posedge iClk);
    #1;
    check("bp_no_ghost_valid", 32'(oValid), 32'd0);
    check("bp_no_ghost_ready", 32'(oReady), 32'd1);

    // Reset in the second BUSY cycle
    @(negedge iClk);
    iValid = 1'b1; iA = 16'hFFFF; iB = 16'h0001; iSub = 1'b0;
    @(posedge iClk); #1;
    iValid = 1'b0;
    @(posedge iClk); #1;
    iRst = 1'b1;
    @(posedge iClk); #1;
    iRst = 1'b0;
    check("midrst_ready", 32'(oReady), 32'd1);
    check("midrst_valid", 32'(oValid), 32'd0);
    check("midrst_s", 32'(oS), 32'd0);
    check("midrst_c", 32'(oC), 32'd0);
    check("midrst_v", 32'(oV), 32'd0);
    run_op(16'h0001, 16'h0001, 1'b0, lat);
    check("post_rst_latency", 32'(lat), 32'd4);
    check("post_rst_s", 32'(oS), 32'h0002);
    check("post_rst_c", 32'(oC), 32'd0);
    check("post_rst_v", 32'(oV), 32'd0);
    ack();

    // Single-chunk build: BUSY lasts one cycle
    run8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run8(8'h05, 8'h07, 1'b1, 8'hFE, 1'b1, 1'b0);
`ifdef ADDSUB_SAT_EN
    run8(8'h80, 8'h01, 1'b1, 8'h80, 1'b0, 1'b1);
`else
    run8(8'h80, 8'h01, 1'b1, 8'h7F, 1'b0, 1'b1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
